enc8b10b_lanes: RTL and testbench
=================================

# enc8b10b_lanes

Multi-lane 8b/10b transmit encoder for the PHY transmit path. It sits between the per-lane byte/K-flag source and the serializers. Each lane keeps its own running disparity. The block adds a valid handshake, per-lane compliance disparity forcing, illegal-K detection and a selectable pipeline depth. Lane count and latency are set by parameters.

## Interface
- LANES, 4, number of independent byte lanes (1–16)
- PIPE_STAGES, 1, encode latency in cycles; legal values are 1 or 2
- INTERCLK  in  1  internal clock; all logic is on the rising edge
- Reset  in  1  synchronous, active-low; clock INTERCLK
- iValid  in  1  qualifies iData, TXDATAK and TXCOMP for all lanes
- iData  in  8*LANES  lane n byte is iData[8n+7:8n]; bit 0 is A (LSB), bit 7 is H
- TXDATAK  in  LANES  1 = lane byte is a control (K) character
- TXCOMP  in  LANES  1 = encode this lane's symbol as if RD were negative
- oValid  out  1  oData, oRD and KERR are valid
- oData  out  10*LANES  lane n symbol is oData[10n+9:10n], ordered {a,b,c,d,e,i,f,g,h,j}; a is the MSB and is transmitted first
- oRD  out  LANES  running disparity after the lane symbol; 0 = negative, 1 = positive
- KERR  out  LANES  TXDATAK was set on a byte that is not a legal K code

## Operation
- Each lane holds one RD flop (0 = RD-). All lanes encode in parallel from the same iValid; there is no cross-lane dependency.
- Encoding is standard IBM 5b/6b plus 3b/4b:
  - The 6b sub-block is selected by the current RD.
  - The 4b sub-block is selected by the RD after the 6b sub-block.
  - The alternate A7 code (0111/1000) is used for D.x.7 when x ∈ {17,18,20} at RD-, or x ∈ {11,13,14} at RD+.
  - K28.y uses 001111/110000 and forces the alternate 4b forms. Kx.7 uses 1110/0001 as 0111/1000.
- Legal K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7 (0x1C,0x3C,…,0xFC,0xF7,0xFB,0xFD,0xFE).
- Illegal K (TXDATAK=1, byte not in that set): the lane encodes the byte as a data byte D.x.y, sets KERR=1, and updates RD normally.
- TXCOMP[n]=1 with iValid: lane n uses RD- as its input disparity for that symbol. The new RD is computed from that forced value. TXCOMP has no effect when iValid=0.
- RD update: RD_next = RD_in XOR (symbol disparity ≠ 0). Every legal symbol has disparity 0 or ±2.
- iValid=0: RD holds, oValid=0 after the pipeline latency, and oData/oRD/KERR hold their last values.

## Timing
- PIPE_STAGES=1: inputs sampled at edge t appear on the outputs after edge t (one-cycle latency).
- PIPE_STAGES=2: an input register is added ahead of the encoder, giving two-cycle latency. RD feedback stays inside the encode stage, so back-to-back valid symbols are fully supported at one symbol per cycle per lane.
- Throughput is one symbol per lane per cycle. There is no backpressure; the downstream side must accept every oValid.
- Reset (Reset=0 at an edge):
  - All RD = 0, oValid = 0, oData = 0, oRD = 0, KERR = 0. The pipeline registers are cleared.
  - Symbols in flight are discarded.
  - Inputs presented during reset are ignored.
- First valid input after reset release is encoded with RD-.
- Reset asserted in the middle of a stream: outputs are cleared on the next edge. A symbol presented together with the reset-deassert edge is not captured; capture starts on the following edge.
- No combinational path from any input to any output.

## Test plan
- After reset, lane0 byte 0xB5 (D21.5) with K=0 → oData[9:0] = 1010101010, oRD[0] = 0, oValid one cycle later (PIPE_STAGES=1).
- Lane0 K28.5 (0xBC, K=1) twice back-to-back from RD- → 0011111010 with oRD=1, then 1100000101 with oRD=0.
- Lane0 D17.7 (0xF1) at RD- → 1000110111 (A7). The same byte at RD+ (reached via K28.5) → 1000110001.
- RD+ state, then K28.5 with TXCOMP[0]=1 → 0011111010, oRD[0]=1. Lane1 sends the same byte without TXCOMP in parallel → 1100000101; lane RDs stay independent.
- TXDATAK=1 with byte 0x00 from RD- → KERR=1 and oData = 1001110100 (D0.0), oRD=0. With iValid=0 next cycle → oValid=0, RD held.
- Reset pulled low mid-stream (LANES=4, PIPE_STAGES=2, RD+ on lanes 0 and 2) → all outputs 0 after the next edge. First symbol after release, D21.5, is encoded from RD- on every lane.

Source files
------------

// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b transmit encoder: per-lane running disparity, compliance RD forcing,
// illegal-K flagging and a 1- or 2-cycle encode pipeline.
module enc8b10b_lanes #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic                 INTERCLK,
    input  logic                 Reset,
    input  logic                 iValid,
    input  logic [8*LANES-1:0]   iData,
    input  logic [LANES-1:0]     TXDATAK,
    input  logic [LANES-1:0]     TXCOMP,
    output logic                 oValid,
    output logic [10*LANES-1:0]  oData,
    output logic [LANES-1:0]     oRD,
    output logic [LANES-1:0]     KERR
);

    // Valid-only handshake: iValid qualifies all lanes on the edge it is sampled; oValid
    // pulses once per accepted symbol set and the sink must take it (no ready/backpressure).

    function automatic logic k_legal(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
    endfunction

    // Returns {rd_next, abcdei, fghj}. Tables hold the RD- form; the RD+ form is the complement
    // whenever the sub-block is unbalanced or is one of the balanced codes with two spellings.
    function automatic logic [10:0] enc_sym(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       k28, un6, un4, rdm, a7;
        x   = b[4:0];
        y   = b[7:5];
        k28 = k && (x == 5'd28);
        case (x)
            5'd0:  s6 = 6'b100111;  5'd1:  s6 = 6'b011101;
            5'd2:  s6 = 6'b101101;  5'd3:  s6 = 6'b110001;
            5'd4:  s6 = 6'b110101;  5'd5:  s6 = 6'b101001;
            5'd6:  s6 = 6'b011001;  5'd7:  s6 = 6'b111000;
            5'd8:  s6 = 6'b111001;  5'd9:  s6 = 6'b100101;
            5'd10: s6 = 6'b010101;  5'd11: s6 = 6'b110100;
            5'd12: s6 = 6'b001101;  5'd13: s6 = 6'b101100;
            5'd14: s6 = 6'b011100;  5'd15: s6 = 6'b010111;
            5'd16: s6 = 6'b011011;  5'd17: s6 = 6'b100011;
            5'd18: s6 = 6'b010011;  5'd19: s6 = 6'b110010;
            5'd20: s6 = 6'b001011;  5'd21: s6 = 6'b101010;
            5'd22: s6 = 6'b011010;  5'd23: s6 = 6'b111010;
            5'd24: s6 = 6'b110011;  5'd25: s6 = 6'b100110;
            5'd26: s6 = 6'b010110;  5'd27: s6 = 6'b110110;
            5'd28: s6 = k28 ? 6'b001111 : 6'b001110;
            5'd29: s6 = 6'b101110;  5'd30: s6 = 6'b011110;
            default: s6 = 6'b101011;
        endcase
        un6 = ($countones(s6) != 3);
        if (rd && (un6 || x == 5'd7))
            s6 = ~s6;
        rdm = rd ^ un6;
        // A7 avoids a run of five equal bits across the sub-block boundary; every legal Kx.7 uses it.
        a7 = k || (!rdm && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                || (rdm && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        case (y)
            3'd0:    s4 = 4'b1011;
            3'd1:    s4 = k28 ? 4'b0110 : 4'b1001;
            3'd2:    s4 = k28 ? 4'b1010 : 4'b0101;
            3'd3:    s4 = 4'b1100;
            3'd4:    s4 = 4'b1101;
            3'd5:    s4 = k28 ? 4'b0101 : 4'b1010;
            3'd6:    s4 = k28 ? 4'b1001 : 4'b0110;
            default: s4 = a7 ? 4'b0111 : 4'b1110;
        endcase
        un4 = ($countones(s4) != 2);
        if (rdm && (un4 || y == 3'd3 || k28))
            s4 = ~s4;
        return {rdm ^ un4, s6, s4};
    endfunction

    logic                 s_valid;
    logic [8*LANES-1:0]   s_data;
    logic [LANES-1:0]     s_k;
    logic [LANES-1:0]     s_comp;

    generate
        if (PIPE_STAGES == 2) begin : g_in_reg
            always_ff @(posedge INTERCLK) begin
                if (!Reset) begin
                    s_valid <= 1'b0;
                    s_data  <= '0;
                    s_k     <= '0;
                    s_comp  <= '0;
                end else begin
                    s_valid <= iValid;
                    s_data  <= iData;
                    s_k     <= TXDATAK;
                    s_comp  <= TXCOMP;
                end
            end
        end else begin : g_no_in_reg
            assign s_valid = iValid;
            assign s_data  = iData;
            assign s_k     = TXDATAK;
            assign s_comp  = TXCOMP;
        end
    endgenerate

    logic [10*LANES-1:0] enc_data;
    logic [LANES-1:0]    enc_rd;
    logic [LANES-1:0]    enc_kerr;

    // oRD doubles as each lane's running-disparity state, so feedback is confined to this stage.
    always_comb begin
        enc_data = '0;
        enc_rd   = '0;
        enc_kerr = '0;
        for (int n = 0; n < LANES; n++) begin
            logic [10:0] res;
            logic        legal;
            legal = k_legal(s_data[8*n +: 8]);
            res   = enc_sym(s_data[8*n +: 8], s_k[n] && legal, s_comp[n] ? 1'b0 : oRD[n]);
            enc_data[10*n +: 10] = res[9:0];
            enc_rd[n]            = res[10];
            enc_kerr[n]          = s_k[n] && !legal;
        end
    end

    always_ff @(posedge INTERCLK) begin
        if (!Reset) begin
            oValid <= 1'b0;
            oData  <= '0;
            oRD    <= '0;
            KERR   <= '0;
        end else begin
            oValid <= s_valid;
            if (s_valid) begin
                oData <= enc_data;
                oRD   <= enc_rd;
                KERR  <= enc_kerr;
            end
        end
    end

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Directed bench for enc8b10b_lanes: a 1-stage and a 2-stage instance share the same stimulus;
// the 2-stage outputs are expected to equal the 1-stage expectation one cycle later.
module tb_enc8b10b_lanes;

    localparam int L = 4;

    localparam logic [9:0] S_D21_5  = 10'b1010101010;
    localparam logic [9:0] S_K285_N = 10'b0011111010;
    localparam logic [9:0] S_K285_P = 10'b1100000101;
    localparam logic [9:0] S_D177_N = 10'b1000110111;
    localparam logic [9:0] S_D177_P = 10'b1000110001;
    localparam logic [9:0] S_D00_N  = 10'b1001110100;
    localparam logic [9:0] S_K237_N = 10'b1110101000;

    logic INTERCLK = 1'b0;
    always #5 INTERCLK = ~INTERCLK;

    logic              Reset;
    logic              iValid;
    logic [8*L-1:0]    iData;
    logic [L-1:0]      TXDATAK;
    logic [L-1:0]      TXCOMP;

    logic              v1, v2;
    logic [10*L-1:0]   d1, d2;
    logic [L-1:0]      rd1, rd2, ke1, ke2;

    enc8b10b_lanes #(.LANES(L), .PIPE_STAGES(1)) u_dut_p1 (
        .INTERCLK(INTERCLK), .Reset(Reset), .iValid(iValid), .iData(iData),
        .TXDATAK(TXDATAK), .TXCOMP(TXCOMP),
        .oValid(v1), .oData(d1), .oRD(rd1), .KERR(ke1)
    );

    enc8b10b_lanes #(.LANES(L), .PIPE_STAGES(2)) u_dut_p2 (
        .INTERCLK(INTERCLK), .Reset(Reset), .iValid(iValid), .iData(iData),
        .TXDATAK(TXDATAK), .TXCOMP(TXCOMP),
        .oValid(v2), .oData(d2), .oRD(rd2), .KERR(ke2)
    );

    int n_vec = 0;
    int n_err = 0;
    int vec_id = 0;

    logic            e_valid = 1'b0, p_valid = 1'b0;
    logic [10*L-1:0] e_data = '0, p_data = '0;
    logic [L-1:0]    e_rd = '0, p_rd = '0, e_kerr = '0, p_kerr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %0h, expected %0h", vec_id, tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic rst_edge;
        rst_edge = !Reset;
        @(posedge INTERCLK);
        #1;
        if (rst_edge) begin
            e_valid = 1'b0; e_data = '0; e_rd = '0; e_kerr = '0;
            p_valid = 1'b0; p_data = '0; p_rd = '0; p_kerr = '0;
        end
        check("p1 oValid", 64'(v1),  64'(e_valid));
        check("p1 oData",  64'(d1),  64'(e_data));
        check("p1 oRD",    64'(rd1), 64'(e_rd));
        check("p1 KERR",   64'(ke1), 64'(e_kerr));
        check("p2 oValid", 64'(v2),  64'(p_valid));
        check("p2 oData",  64'(d2),  64'(p_data));
        check("p2 oRD",    64'(rd2), 64'(p_rd));
        check("p2 KERR",   64'(ke2), 64'(p_kerr));
        p_valid = e_valid; p_data = e_data; p_rd = e_rd; p_kerr = e_kerr;
        vec_id++;
    endtask

    task automatic apply(input logic v, input logic [8*L-1:0] d, input logic [L-1:0] k,
                         input logic [L-1:0] c, input logic [10*L-1:0] xd,
                         input logic [L-1:0] xrd, input logic [L-1:0] xk);
        iValid  = v;
        iData   = d;
        TXDATAK = k;
        TXCOMP  = c;
        e_valid = v;
        if (v) begin
            e_data = xd;
            e_rd   = xrd;
            e_kerr = xk;
        end
        tick();
    endtask

    initial begin
        Reset = 1'b0; iValid = 1'b0; iData = '0; TXDATAK = '0; TXCOMP = '0;
        // Inputs during reset are ignored.
        apply(1'b1, {4{8'hBC}}, 4'hF, 4'h0, '1, 4'hF, 4'h0);
        apply(1'b1, {4{8'hBC}}, 4'hF, 4'h0, '1, 4'hF, 4'h0);
        Reset = 1'b1;
        apply(1'b0, {4{8'h00}}, 4'h0, 4'h0, '0, 4'h0, 4'h0);
        // D21.5 on all lanes
        apply(1'b1, {4{8'hB5}}, 4'h0, 4'h0, {4{S_D21_5}}, 4'b0000, 4'h0);
        // K28.5 back to back on lane 0
        apply(1'b1, {8'hB5, 8'hB5, 8'hB5, 8'hBC}, 4'b0001, 4'h0,
              {S_D21_5, S_D21_5, S_D21_5, S_K285_N}, 4'b0001, 4'h0);
        apply(1'b1, {8'hB5, 8'hB5, 8'hB5, 8'hBC}, 4'b0001, 4'h0,
              {S_D21_5, S_D21_5, S_D21_5, S_K285_P}, 4'b0000, 4'h0);
        // D17.7 from RD- (A7), then from RD+ (primary)
        apply(1'b1, {8'hB5, 8'hB5, 8'hB5, 8'hF1}, 4'b0000, 4'h0,
              {S_D21_5, S_D21_5, S_D21_5, S_D177_N}, 4'b0001, 4'h0);
        apply(1'b1, {8'hB5, 8'hB5, 8'hB5, 8'hF1}, 4'b0000, 4'h0,
              {S_D21_5, S_D21_5, S_D21_5, S_D177_P}, 4'b0000, 4'h0);
        // Lanes 0/1 to RD+, then compliance forcing on lane 0 only
        apply(1'b1, {8'hB5, 8'hB5, 8'hBC, 8'hBC}, 4'b0011, 4'h0,
              {S_D21_5, S_D21_5, S_K285_N, S_K285_N}, 4'b0011, 4'h0);
        apply(1'b1, {8'hB5, 8'hB5, 8'hBC, 8'hBC}, 4'b0011, 4'b0001,
              {S_D21_5, S_D21_5, S_K285_P, S_K285_N}, 4'b0001, 4'h0);
        // Legal K23.7 on lane 3, illegal K 0x00 on lane 2
        apply(1'b1, {8'hF7, 8'h00, 8'hB5, 8'hB5}, 4'b1100, 4'h0,
              {S_K237_N, S_D00_N, S_D21_5, S_D21_5}, 4'b0001, 4'b0100);
        // Idle cycle with TXCOMP set: outputs hold, RD (lane 0 still RD+) untouched
        apply(1'b0, {4{8'hF1}}, 4'h0, 4'hF, '0, 4'h0, 4'h0);
        apply(1'b1, {8'hB5, 8'hB5, 8'hB5, 8'hF1}, 4'b0000, 4'h0,
              {S_D21_5, S_D21_5, S_D21_5, S_D177_P}, 4'b0000, 4'h0);
        // Lanes 0 and 2 to RD+, then reset mid-stream with a symbol in flight
        apply(1'b1, {8'hB5, 8'hBC, 8'hB5, 8'hBC}, 4'b0101, 4'h0,
              {S_D21_5, S_K285_N, S_D21_5, S_K285_N}, 4'b0101, 4'h0);
        Reset = 1'b0;
        apply(1'b1, {4{8'hB5}}, 4'h0, 4'h0, {4{S_D21_5}}, 4'b0101, 4'h0);
        Reset = 1'b1;
        apply(1'b0, {4{8'hB5}}, 4'h0, 4'h0, '0, 4'h0, 4'h0);
        apply(1'b1, {4{8'hB5}}, 4'h0, 4'h0, {4{S_D21_5}}, 4'b0000, 4'h0);
        apply(1'b1, {4{8'hBC}}, 4'hF, 4'h0, {4{S_K285_N}}, 4'b1111, 4'h0);
        apply(1'b0, {4{8'h00}}, 4'h0, 4'h0, '0, 4'h0, 4'h0);
        apply(1'b0, {4{8'h00}}, 4'h0, 4'h0, '0, 4'h0, 4'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
